// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel pushbutton conditioner for the stopwatch
// front panel. Every channel is an independent copy of the same pipeline:
//   2-flop synchronizer -> counter debounce -> press/release/repeat FSM.
//
// Ports
//   clk    : system clock, all logic on posedge
//   rst    : synchronous, active-high reset
//   btn    : raw asynchronous button inputs, 1 = pressed
//   level  : debounced button state
//   press  : one-cycle pulse when level goes 0->1
//   rel    : one-cycle pulse when level goes 1->0
//            (named rel because "release" is a reserved word)
//   pulse  : press pulse plus auto-repeat pulses while held (if REPEAT_EN)
//
// Timing: press, rel and pulse are registered on the same edge that
// updates level, so a press is visible in the same cycle as the new level.
module btn_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel,
  output logic [N_BTN-1:0] pulse
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);

  // Counter values at which the *next* increment would complete the interval;
  // the action fires on that edge instead of storing the terminal count.
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]   DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]   RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]      sync_q;
    logic            btn_s;
    logic            level_q, level_d;
    logic [DB_W-1:0] db_q, db_d;
    logic            rise, fall;
    state_t          state_q, state_d;
    logic [RW-1:0]   rpt_q, rpt_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            pulse_q, pulse_d;

    assign btn_s = sync_q[1];

    // Debounce: count consecutive synchronized samples that disagree with
    // level; accept the change on the edge that would reach the limit.
    always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      db_d    = db_q;
      level_d = level_q;
      rise    = 1'b0;
      fall    = 1'b0;
      if (btn_s == level_q) begin
        db_d = '0;
      end else if (db_q == DB_LAST) begin
        db_d    = '0;
        level_d = ~level_q;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        db_d = db_q + DB_W'(1);
      end
    end

    // Press/release/repeat FSM. It reacts to the level change being accepted
    // on this edge, so its registered pulses line up with the new level.
    always_comb begin
      state_d = state_q;
      rpt_d   = rpt_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = PRESSED;
            press_d = 1'b1;
            pulse_d = 1'b1;
            rpt_d   = '0;
          end
        end
        PRESSED: begin
          if (fall) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            rpt_d   = '0;
          end else if (REPEAT_EN != 0) begin
            if (rpt_q == DELAY_LAST) begin
              state_d = REPEATING;
              pulse_d = 1'b1;
              rpt_d   = '0;
            end else begin
              rpt_d = rpt_q + RW'(1);
            end
          end
        end
        REPEATING: begin
          // Release wins over a coincident repeat pulse.
          if (fall) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            rpt_d   = '0;
          end else if (rpt_q == RATE_LAST) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + RW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rpt_d   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
        sync_q  <= '0;
        level_q <= 1'b0;
        db_q    <= '0;
        state_q <= IDLE;
        rpt_q   <= '0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], btn[i]};
        level_q <= level_d;
        db_q    <= db_d;
        state_q <= state_d;
        rpt_q   <= rpt_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        pulse_q <= pulse_d;
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
    assign pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner. Two instances share clk/rst:
//   u_a : REPEAT_EN=0 (debounce, bounce, release, reset-mid-press)
//   u_b : REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=3 (auto-repeat, same-edge press)
// Outputs are sampled 1 time unit after each rising edge; "cycle k" means the
// values visible after the k-th counted edge, E0 being the first edge that
// samples the new button value.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_a, btn_b;
  logic [3:0] level_a, press_a, rel_a, pulse_a;
  logic [3:0] level_b, press_b, rel_b, pulse_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_a (
    .clk(clk), .rst(rst), .btn(btn_a),
    .level(level_a), .press(press_a), .rel(rel_a), .pulse(pulse_a)
  );

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) u_b (
    .clk(clk), .rst(rst), .btn(btn_b),
    .level(level_b), .press(press_b), .rel(rel_b), .pulse(pulse_b)
  );

  typedef struct packed {
    logic [3:0] btn;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    logic [3:0] pls;
  } vec_t;

  localparam int N_VEC = 40;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_pls3, n_rls3, n_prs3;
    logic e;

    // Table, channels staggered in time (index = edge number after reset):
    //  ch0: held from E0            -> press at 5, level stays 1
    //  ch1: 1,1,1,0 then held (E8..) -> 4 consecutive highs end at b[15] -> press at 17
    //  ch2: high 20..29, low 30, high 31, low from 32 -> press 25, release 37
    //  ch3: glitch at 10, then 3-cycle pulse 12..14  -> never accepted
    for (int i = 0; i < N_VEC; i++) begin
      vecs[i].btn = {(i == 10) || (i >= 12 && i <= 14),
                     (i >= 20 && i <= 29) || (i == 31),
                     (i >= 8 && i <= 10) || (i >= 12),
                     1'b1};
      vecs[i].lvl = {1'b0, (i >= 25 && i < 37), (i >= 17), (i >= 5)};
      vecs[i].prs = {1'b0, (i == 25), (i == 17), (i == 5)};
      vecs[i].rls = {1'b0, (i == 37), 1'b0, 1'b0};
      vecs[i].pls = vecs[i].prs;  // REPEAT_EN=0: pulse is press only
    end

    // Reset with buttons held: nothing may come out.
    rst   = 1'b1;
    btn_a = 4'hF;
    btn_b = 4'hF;
    step();
    step();
    check("rst level_a", level_a, 4'h0);
    check("rst press_a", press_a, 4'h0);
    check("rst rel_a",   rel_a,   4'h0);
    check("rst pulse_a", pulse_a, 4'h0);
    check("rst level_b", level_b, 4'h0);
    check("rst press_b", press_b, 4'h0);
    check("rst rel_b",   rel_b,   4'h0);
    check("rst pulse_b", pulse_b, 4'h0);

    rst   = 1'b0;
    btn_b = 4'h0;
    for (int i = 0; i < N_VEC; i++) begin
      btn_a = vecs[i].btn;
      step();
      check($sformatf("tbl[%0d] level", i), level_a, vecs[i].lvl);
      check($sformatf("tbl[%0d] press", i), press_a, vecs[i].prs);
      check($sformatf("tbl[%0d] rel", i),   rel_a,   vecs[i].rls);
      check($sformatf("tbl[%0d] pulse", i), pulse_a, vecs[i].pls);
    end

    // Auto-repeat on u_b: ch0 and ch3 rise on the same edge and are held
    // through E36. Press at P=5, repeats at 15,18,...,39. Release at 42, which
    // is exactly where the next repeat would have fallen, so no pulse there.
    // Meanwhile u_a keeps ch0 held only, so it sits in PRESSED.
    btn_a  = 4'b0001;
    n_pls3 = 0;
    n_rls3 = 0;
    n_prs3 = 0;
    for (int c = 0; c < 50; c++) begin
      btn_b = (c <= 36) ? 4'b1001 : 4'b0000;
      step();
      e = (c == 5) || (c >= 15 && c <= 39 && ((c - 15) % 3) == 0);
      check($sformatf("rpt[%0d] pulse", c), pulse_b, {e, 2'b00, e});
      check($sformatf("rpt[%0d] press", c), press_b, (c == 5) ? 4'b1001 : 4'b0000);
      check($sformatf("rpt[%0d] rel", c),   rel_b,   (c == 42) ? 4'b1001 : 4'b0000);
      check($sformatf("rpt[%0d] level", c), level_b, (c >= 5 && c < 42) ? 4'b1001 : 4'b0000);
      n_pls3 += int'(pulse_b[3]);
      n_rls3 += int'(rel_b[3]);
      n_prs3 += int'(press_b[3]);
    end
    check("rpt pulse[3] count",   n_pls3, 10);
    check("rpt release[3] count", n_rls3, 1);
    check("rpt press[3] count",   n_prs3, 1);

    // Reset while u_a ch0 is held in PRESSED: all clear next cycle, then a
    // fresh press 5 edges after the first post-reset sample, never a release.
    check("pre-rst level_a", level_a, 4'b0001);
    rst = 1'b1;
    step();
    check("midrst level_a", level_a, 4'h0);
    check("midrst press_a", press_a, 4'h0);
    check("midrst rel_a",   rel_a,   4'h0);
    check("midrst pulse_a", pulse_a, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("post[%0d] level", k), level_a, (k >= 5) ? 4'b0001 : 4'b0000);
      check($sformatf("post[%0d] press", k), press_a, (k == 5) ? 4'b0001 : 4'b0000);
      check($sformatf("post[%0d] rel", k),   rel_a,   4'b0000);
      check($sformatf("post[%0d] pulse", k), pulse_a, (k == 5) ? 4'b0001 : 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Multi-channel pushbutton conditioner for the stopwatch front panel. It is the parametrised successor of the single-button press-to-pulse FSM. Per channel it provides a 2-flop synchronizer, a counter-based debounce filter, one-cycle press and release pulses, and an optional auto-repeat pulse train while the button is held. Outputs feed the stopwatch control FSM (start/stop, lap, reset, mode keys).

Parameters:
N_BTN, 4, number of independent button channels
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (>=1)
REPEAT_EN, 0, 1 enables auto-repeat on pulse output
REPEAT_DELAY, 10, cycles from press pulse to first repeat pulse (>=1, used only if REPEAT_EN=1)
REPEAT_RATE, 3, cycles between subsequent repeat pulses (>=1, used only if REPEAT_EN=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
btn  in  N_BTN  raw asynchronous button inputs, 1 = pressed
level  out  N_BTN  debounced button state
press  out  N_BTN  one-cycle pulse on accepted 0->1 of level
release  out  N_BTN  one-cycle pulse on accepted 1->0 of level
pulse  out  N_BTN  press OR auto-repeat pulse, one cycle each

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst=1 at a posedge, the following are all cleared to 0 on that edge, for every channel: level, press, release, pulse, synchronizer flops, debounce counter, repeat counter, FSM state (IDLE).
- Channels are fully independent; the per-channel logic below is replicated N_BTN times.
- Synchronizer: btn_s = btn delayed through 2 flops.
- Debounce:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If btn_s == level, the counter clears.
  - Otherwise the counter increments. When the increment would reach DEBOUNCE_CYCLES, level toggles and the counter clears on that same edge.
  - Any sample with btn_s == level before then restarts the count. A glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles produces no output activity.
- Latency: let E0 be the first edge that samples btn=1, with btn held high. level and press become 1 after edge E(DEBOUNCE_CYCLES+1). Release uses the same latency.
- FSM states are IDLE, PRESSED and REPEATING.
  - IDLE -> PRESSED on level rising: press=1 and pulse=1 for one cycle; repeat counter clears.
  - PRESSED, when level falls: release=1 for one cycle, then go to IDLE.
  - PRESSED, when level holds and REPEAT_EN=1: the repeat counter increments each cycle. REPEAT_DELAY cycles after the press-pulse cycle, pulse=1 for one cycle, the counter clears, and the FSM moves to REPEATING.
  - PRESSED with REPEAT_EN=0: the FSM stays in PRESSED until level falls.
  - REPEATING: pulse=1 every REPEAT_RATE cycles while level=1. When level falls: release=1, the counter clears, go to IDLE. A repeat pulse is never emitted in the release cycle.
- press, release and pulse are registered. press and release are never high in the same cycle on one channel.
- Holding a button produces exactly one press; the press and release counts on a channel always pair up.
- Reset mid-press: outputs are 0 the cycle after the reset edge. If btn is still held after rst deasserts, the channel debounces from scratch and emits a fresh press after the normal latency. No release is generated for the interrupted press.
- btn X or Z during reset is a don't-care.

Test Plan:
- N_BTN=4, DEBOUNCE_CYCLES=4, REPEAT_EN=0; btn[0] 0->1 at E0 and held 20 cycles -> level[0]=1 and press[0]=1 exactly one cycle after E5. pulse[0] equals press[0]. Other channels stay 0.
- btn[1] high for 3 cycles, low for 1, high for 3 (bounce), then held -> no press until 4 consecutive synchronized high samples. Exactly one press[1] in total.
- btn[2] held then released; release bounces 2 cycles -> exactly one release[2], 5 edges after the first sampled low. level[2] drops in the same cycle.
- REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_RATE=3; btn[3] held 30 cycles after press -> pulse[3] at press cycle P, then P+10, P+13, P+16, ... Pulses stop in the release cycle; release[3] fires once.
- btn[0] and btn[3] change on the same edge -> both press pulses occur in the same cycle, independently.
- rst asserted while btn[0] held in PRESSED -> all outputs 0 next cycle. After rst deasserts with btn still held, a new press[0] appears 5 edges after the first post-reset sample. No release[0] is emitted.
